mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous data/instruction memory between two requesters: port 0 is the multicycle RISC-V core, port 1 is the loader/DMA.
- Each port uses a valid/ready request handshake and gets a one-cycle response pulse.
- A per-port lock keeps the grant across multi-access sequences, e.g. the core's store read-modify-write, so they are atomic.
- Memory has 1-cycle read latency: address/we are sampled at clk edge N, and mem_rdata is valid during cycle N+1.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/arb_pick.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int   NUM_PORTS = 2;
    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    // Default request geometry (matches the arbiter's default parameters).
    localparam int REQ_AW = 32;
    localparam int REQ_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [REQ_AW-1:0]     addr;
        logic [REQ_DW-1:0]     wdata;
        logic [REQ_DW/8-1:0]   wmask;
    } mem_req_t;

    // The port that did not win last time.
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection for the two-port arbiter.
// The tie-break policy lives here so the FSM stays policy-agnostic.
// Build option ARB_RR_EN: ties alternate away from the last winner;
// without it ties always go to the CPU port.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid_i,
    input  logic                 locked_i,
    input  logic                 grant_id_i,
`ifdef ARB_RR_EN
    input  logic                 last_winner_i,
`endif
    output logic                 winner_o,
    output logic                 any_o
);

    logic tie_winner_s;

`ifdef ARB_RR_EN
    assign tie_winner_s = other_port(last_winner_i);
`else
    assign tie_winner_s = PORT_CPU;
`endif

    // Lock pins the grant to the current owner; otherwise single valid wins, ties use the policy.
    always_comb begin
        winner_o = grant_id_i;
        any_o    = 1'b0;
        if (locked_i) begin
            winner_o = grant_id_i;
            any_o    = valid_i[grant_id_i];
        end else begin
            case (valid_i)
                2'b01: begin
                    winner_o = PORT_CPU;
                    any_o    = 1'b1;
                end
                2'b10: begin
                    winner_o = PORT_DMA;
                    any_o    = 1'b1;
                end
                2'b11: begin
                    winner_o = tie_winner_s;
                    any_o    = 1'b1;
                end
                default: begin
                    winner_o = grant_id_i;
                    any_o    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port synchronous memory (1-cycle read
// latency) between the CPU (port 0) and the loader/DMA (port 1).
// Each transaction walks IDLE -> ISSUE -> RESP; a per-port lock keeps the
// grant across multi-access sequences such as read-modify-write.
// Build option ARB_RR_EN enables round-robin tie-breaking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_valid_i,
    output logic            m0_ready_o,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_wdata_i,
    input  logic [DW/8-1:0] m0_wmask_i,
    input  logic            m0_lock_i,
    output logic            m0_rsp_valid_o,
    output logic [DW-1:0]   m0_rdata_o,
    input  logic            m1_valid_i,
    output logic            m1_ready_o,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_wdata_i,
    input  logic [DW/8-1:0] m1_wmask_i,
    input  logic            m1_lock_i,
    output logic            m1_rsp_valid_o,
    output logic [DW-1:0]   m1_rdata_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_wmask_o,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            grant_id_o,
    output logic            busy_o
);

    localparam int MW = DW / 8;

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
    localparam logic [1:0] ST_RESP  = 2'(RESP);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 grant_id_q;
    logic                 locked_q;
    logic                 lock_pend_q;
    logic                 req_we_q;
    logic                 mem_we_q;
    logic [AW-1:0]        mem_addr_q;
    logic [DW-1:0]        mem_wdata_q;
    logic [MW-1:0]        mem_wmask_q;
`ifdef ARB_RR_EN
    logic                 last_winner_q;
`endif

    logic [NUM_PORTS-1:0] valid_s;
    logic                 winner_s;
    logic                 any_s;
    logic                 accept_s;
    logic                 sel_we_s;
    logic                 sel_lock_s;
    logic [AW-1:0]        sel_addr_s;
    logic [DW-1:0]        sel_wdata_s;
    logic [MW-1:0]        sel_wmask_s;

    assign valid_s = {m1_valid_i, m0_valid_i};

    arb_pick u_pick (
        .valid_i       (valid_s),
        .locked_i      (locked_q),
        .grant_id_i    (grant_id_q),
`ifdef ARB_RR_EN
        .last_winner_i (last_winner_q),
`endif
        .winner_o      (winner_s),
        .any_o         (any_s)
    );

    // Requests are only taken while idle; ready is a pure decode of that.
    assign accept_s   = (state_q == ST_IDLE) && any_s;
    assign m0_ready_o = accept_s && (winner_s == PORT_CPU);
    assign m1_ready_o = accept_s && (winner_s == PORT_DMA);

    // Route the winning port's request fields toward the capture registers.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        sel_wmask_s = {MW{1'b0}};
        if (winner_s == PORT_DMA) begin
            sel_we_s    = m1_we_i;
            sel_lock_s  = m1_lock_i;
            sel_addr_s  = m1_addr_i;
            sel_wdata_s = m1_wdata_i;
            sel_wmask_s = m1_wmask_i;
        end else begin
            sel_we_s    = m0_we_i;
            sel_lock_s  = m0_lock_i;
            sel_addr_s  = m0_addr_i;
            sel_wdata_s = m0_wdata_i;
            sel_wmask_s = m0_wmask_i;
        end
    end

    // Transaction sequencing: one access per three cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, grant, lock and memory-side registers; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= PORT_CPU;
            locked_q      <= 1'b0;
            lock_pend_q   <= 1'b0;
            req_we_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= {AW{1'b0}};
            mem_wdata_q   <= {DW{1'b0}};
            mem_wmask_q   <= {MW{1'b0}};
`ifdef ARB_RR_EN
            last_winner_q <= PORT_DMA;
`endif
        end else begin
            state_q  <= state_d;
            mem_we_q <= 1'b0;
            if (accept_s) begin
                grant_id_q    <= winner_s;
                lock_pend_q   <= sel_lock_s;
                req_we_q      <= sel_we_s;
                mem_we_q      <= sel_we_s;
                mem_addr_q    <= sel_addr_s;
                mem_wdata_q   <= sel_wdata_s;
                mem_wmask_q   <= sel_wmask_s;
`ifdef ARB_RR_EN
                last_winner_q <= winner_s;
`endif
            end else begin
                grant_id_q    <= grant_id_q;
            end
            // The lock request captured at accept takes effect once the access is issued.
            if (state_q == ST_ISSUE) begin
                locked_q <= lock_pend_q;
            end else begin
                locked_q <= locked_q;
            end
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;
    assign mem_we_o    = mem_we_q;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = (state_q != ST_IDLE);

    // Response pulse goes to the owner; read data is forwarded straight from memory.
    assign m0_rsp_valid_o = (state_q == ST_RESP) && (grant_id_q == PORT_CPU);
    assign m1_rsp_valid_o = (state_q == ST_RESP) && (grant_id_q == PORT_DMA);
    assign m0_rdata_o     = (m0_rsp_valid_o && !req_we_q) ? mem_rdata_i : {DW{1'b0}};
    assign m1_rdata_o     = (m1_rsp_valid_o && !req_we_q) ? mem_rdata_i : {DW{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready, m0_we, m0_lock, m0_rsp_valid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m1_valid, m1_ready, m1_we, m1_lock, m1_rsp_valid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic        grant_id, busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_we_i(m0_we),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wmask_i(m0_wmask),
        .m0_lock_i(m0_lock), .m0_rsp_valid_o(m0_rsp_valid), .m0_rdata_o(m0_rdata),
        .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_we_i(m1_we),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wmask_i(m1_wmask),
        .m1_lock_i(m1_lock), .m1_rsp_valid_o(m1_rsp_valid), .m1_rdata_o(m1_rdata),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata),
        .grant_id_o(grant_id), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory behind the arbiter: synchronous read, byte-masked write.
    logic [31:0] mem_arr [0:255];
    always @(posedge clk) begin
        mem_rdata <= mem_arr[mem_addr[9:2]];
        if (mem_we) mem_arr[mem_addr[9:2]] <= merge(mem_arr[mem_addr[9:2]], mem_wdata, mem_wmask);
    end

    // Transaction-level reference: an access accepted at cycle T is issued at T+1,
    // answered at T+2, and the arbiter is free again at T+3.
    logic [31:0] ref_mem [0:255];
    int          cyc = 0;
    int          t_acc = -100;
    logic        m_owner, m_we, m_locked, m_grant, m_last;
    logic [31:0] m_addr, m_wdata, m_rdexp;
    logic [3:0]  m_wmask;

    always @(negedge clk) begin : model_p
        logic       idle, have, win;
        logic [1:0] cand;
        logic [7:0] idx;
        cyc++;
        if (reset) begin
            t_acc = -100; m_locked = 1'b0; m_grant = 1'b0; m_last = 1'b1;
            m_owner = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wmask = 4'h0;
        end else begin
            idle = (cyc >= t_acc + 3);
            cand = {m1_valid, m0_valid};
            if (m_locked) cand = cand & (m_grant ? 2'b10 : 2'b01);
            have = (cand != 2'b00);
`ifdef ARB_RR_EN
            if (cand == 2'b11) win = ~m_last; else win = cand[1];
`else
            if (cand == 2'b11) win = 1'b0; else win = cand[1];
`endif
            chk("ready0", m0_ready, idle && have && !win);
            chk("ready1", m1_ready, idle && have && win);
            chk("busy", busy, (cyc == t_acc + 1) || (cyc == t_acc + 2));
            chk("mem_we", mem_we, (cyc == t_acc + 1) && m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wmask", mem_wmask, m_wmask);
            chk("grant_id", grant_id, m_grant);
            chk("rsp0", m0_rsp_valid, (cyc == t_acc + 2) && !m_owner);
            chk("rsp1", m1_rsp_valid, (cyc == t_acc + 2) && m_owner);
            if (cyc == t_acc + 2) begin
                if (m_owner) chk("rdata1", m1_rdata, m_we ? 32'h0 : m_rdexp);
                else         chk("rdata0", m0_rdata, m_we ? 32'h0 : m_rdexp);
            end
            if (idle && have) begin
                t_acc = cyc; m_owner = win; m_grant = win; m_last = win;
                m_we    = win ? m1_we    : m0_we;
                m_addr  = win ? m1_addr  : m0_addr;
                m_wdata = win ? m1_wdata : m0_wdata;
                m_wmask = win ? m1_wmask : m0_wmask;
                m_locked = win ? m1_lock : m0_lock;
                idx = m_addr[9:2];
                m_rdexp = ref_mem[idx];
                if (m_we) ref_mem[idx] = merge(ref_mem[idx], m_wdata, m_wmask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        pv[2], pwe[2], plk[2], acc_prev[2];
    logic [31:0] pad[2], pwd[2];
    logic [3:0]  pwm[2];
    int          ng, m1_seen, we_cnt;
    logic        seq[8];

    initial begin
        reset = 1'b1;
        m0_valid = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wmask = 4'h0; m0_lock = 1'b0;
        m1_valid = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wmask = 4'h0; m1_lock = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = {8'(i), 8'(i ^ 8'h5A), 8'(i + 8'd3), 8'(~i)};
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready0", m0_ready, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp0", m0_rsp_valid, 1'b0);
        tick();

        // Single read from 0x10.
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_lock = 1'b0;
        @(negedge clk); chk("rd_ready", m0_ready, 1'b1); tick(); m0_valid = 1'b0;
        @(negedge clk); chk("rd_memwe", mem_we, 1'b0); chk("rd_addr", mem_addr, 32'h10); tick();
        @(negedge clk); chk("rd_rsp", m0_rsp_valid, 1'b1); chk("rd_rdata", m0_rdata, 32'hDEADBEEF); tick();
        @(negedge clk); chk("rd_busy_T3", busy, 1'b0); tick();

        // Masked write from port 1.
        m1_valid = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h000000AB; m1_wmask = 4'b0001; m1_lock = 1'b0;
        @(negedge clk); chk("wr_ready", m1_ready, 1'b1); chk("wr_ready0", m0_ready, 1'b0); tick(); m1_valid = 1'b0;
        @(negedge clk); chk("wr_memwe", mem_we, 1'b1); chk("wr_mask", mem_wmask, 4'b0001); chk("wr_data", mem_wdata, 32'hAB); tick();
        @(negedge clk); chk("wr_memwe_off", mem_we, 1'b0); chk("wr_rsp", m1_rsp_valid, 1'b1); chk("wr_rdata", m1_rdata, 32'h0); tick();
        @(negedge clk); chk("wr_busy_T3", busy, 1'b0); tick();

        // Both ports requesting continuously for four transactions.
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 32'h34;
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m0_ready && ng < 8) begin seq[ng] = 1'b0; ng++; end
            if (m1_ready && ng < 8) begin seq[ng] = 1'b1; ng++; end
            tick();
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        chk("tie_count", ng, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            chk("tie_order", seq[i], 1'(i % 2));
`else
            chk("tie_order", seq[i], 1'b0);
`endif
        end
        tick();

        // Lock: port 0 holds the grant across two accesses while port 1 waits.
        m1_valid = 1'b1; m1_we = 1'b1; m1_addr = 32'h80; m1_wdata = 32'h55; m1_wmask = 4'hF; m1_lock = 1'b0;
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h40; m0_lock = 1'b1;
        @(negedge clk); chk("lk_first", m0_ready, 1'b1); tick(); m0_valid = 1'b0;
        m1_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); if (m1_ready) m1_seen++; tick();
        end
        m0_valid = 1'b1; m0_we = 1'b1; m0_wdata = 32'hCAFE0000; m0_wmask = 4'hC; m0_lock = 1'b0;
        @(negedge clk); chk("lk_second", m0_ready, 1'b1); chk("lk_m1_blocked", m1_seen, 0); tick(); m0_valid = 1'b0;
        tick(); tick();
        @(negedge clk); chk("lk_release", m1_ready, 1'b1); tick(); m1_valid = 1'b0;
        repeat (3) tick();

        // Reset while a locked write is in ISSUE.
        m1_valid = 1'b1; m1_we = 1'b1; m1_addr = 32'h90; m1_wdata = 32'h77; m1_wmask = 4'hF; m1_lock = 1'b1;
        @(negedge clk); chk("rs_acc", m1_ready, 1'b1); tick(); m1_valid = 1'b0; reset = 1'b1;
        @(negedge clk); tick();
        reset = 1'b0; m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 32'h94; m1_lock = 1'b0;
        @(negedge clk);
        chk("rs_memwe", mem_we, 1'b0); chk("rs_rsp", m1_rsp_valid, 1'b0);
        chk("rs_grant", grant_id, 1'b0); chk("rs_busy", busy, 1'b0); chk("rs_fresh", m1_ready, 1'b1);
        tick(); m1_valid = 1'b0;
        repeat (3) tick();

        // Port 1 raises valid for one cycle while port 0 owns the lock.
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h44; m0_lock = 1'b1;
        @(negedge clk); chk("wd_lock", m0_ready, 1'b1); tick(); m0_valid = 1'b0;
        m1_valid = 1'b1; m1_we = 1'b1; m1_addr = 32'hA0; m1_wdata = 32'h99; m1_wmask = 4'hF;
        @(negedge clk); tick(); m1_valid = 1'b0;
        m1_seen = 0; we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m1_ready || m1_rsp_valid) m1_seen++;
            if (mem_we) we_cnt++;
            tick();
        end
        chk("wd_m1", m1_seen, 0); chk("wd_memwe", we_cnt, 0);
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h44; m0_lock = 1'b0;
        @(negedge clk); chk("wd_unlock", m0_ready, 1'b1); tick(); m0_valid = 1'b0;
        repeat (3) tick();

        // Randomized traffic; request fields stay stable while waiting.
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; acc_prev[p] = 1'b0; pwe[p] = 1'b0; plk[p] = 1'b0;
            pad[p] = 32'h0; pwd[p] = 32'h0; pwm[p] = 4'h0;
        end
        for (int k = 0; k < 3000; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] || acc_prev[p]) begin
                    pv[p]  = ($urandom_range(0, 99) < 45);
                    pwe[p] = $urandom_range(0, 1) == 1;
                    plk[p] = ($urandom_range(0, 99) < 30);
                    pad[p] = 32'($urandom_range(0, 255)) << 2;
                    pwd[p] = $urandom;
                    pwm[p] = 4'($urandom_range(0, 15));
                end else if ($urandom_range(0, 99) < 5) begin
                    pv[p] = 1'b0;
                end
            end
            reset = ($urandom_range(0, 399) == 0);
            m0_valid = pv[0]; m0_we = pwe[0]; m0_addr = pad[0]; m0_wdata = pwd[0]; m0_wmask = pwm[0]; m0_lock = plk[0];
            m1_valid = pv[1]; m1_we = pwe[1]; m1_addr = pad[1]; m1_wdata = pwd[1]; m1_wmask = pwm[1]; m1_lock = plk[1];
            @(negedge clk);
            acc_prev[0] = m0_ready && !reset;
            acc_prev[1] = m1_ready && !reset;
            tick();
        end
        reset = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
